// File: rtl/mapped_out_misr_if.sv
`default_nettype none
// ============================================================================
//  Module      : mapped_out_misr_if
//  Description : Vector stream between the mapped netlist harness and the
//                MISR capture stage. The master drives the netlist outputs
//                together with the golden vector; the slave returns ready.
//  Revision    : 1.0  initial release
// ============================================================================
interface mapped_out_misr_if #(
    parameter int OUT_W = 8
);
    logic             vec_valid;
    logic             vec_ready;
    logic [OUT_W-1:0] vec_data;
    logic [OUT_W-1:0] exp_data;
    logic             vec_last;

    modport master (
        output vec_valid,
        output vec_data,
        output exp_data,
        output vec_last,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  vec_data,
        input  exp_data,
        input  vec_last,
        output vec_ready
    );
endinterface
`default_nettype wire

// File: rtl/mapped_out_misr.sv
`default_nettype none
// ============================================================================
//  Module      : mapped_out_misr
//  Description : Capture stage for the mapped benchmark netlist. Each accepted
//                vector is folded into a MISR signature, counted, and compared
//                against the golden vector (saturating mismatch counter).
//                Optional first-failure log enabled by MISR_FAILLOG_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module mapped_out_misr #(
    parameter int               OUT_W = 8,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter int               CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    mapped_out_misr_if.slave      vif,
    output logic                  busy,
    output logic                  done,
    output logic [SIG_W-1:0]      sig_out,
    output logic [CNT_W-1:0]      vec_cnt,
    output logic [CNT_W-1:0]      mis_cnt,
    output logic [CNT_W-1:0]      fail_idx,
    output logic [OUT_W-1:0]      fail_diff
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_vec_ready;
    logic [SIG_W-1:0] r_sig;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    logic             w_accept;
    logic             w_mismatch;
    logic             w_start_run;
    logic [SIG_W-1:0] w_sig_next;

    // Ready is a registered copy of "state is RUN", so accept never depends
    // combinationally on anything but vec_valid and a flop.
    assign w_accept    = vif.vec_valid & r_vec_ready;
    assign w_mismatch  = (vif.vec_data != vif.exp_data);
    // start only matters outside RUN; inside RUN it is ignored.
    assign w_start_run = start & (r_state != S_RUN);
    assign w_sig_next  = {r_sig[SIG_W-2:0], 1'b0}
                       ^ (r_sig[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                       ^ SIG_W'(vif.vec_data);

    // Run-control FSM together with the signature and counters it gates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_vec_ready <= 1'b0;
            r_sig       <= '0;
            r_vec_cnt   <= '0;
            r_mis_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_run) begin
                        r_state     <= S_RUN;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_vec_ready <= 1'b1;
                        r_sig       <= '0;
                        r_vec_cnt   <= '0;
                        r_mis_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_sig <= w_sig_next;
                        if (!(&r_vec_cnt)) begin
                            r_vec_cnt <= r_vec_cnt + CNT_W'(1);
                        end
                        if (w_mismatch && !(&r_mis_cnt)) begin
                            r_mis_cnt <= r_mis_cnt + CNT_W'(1);
                        end
                        if (vif.vec_last) begin
                            r_state     <= S_DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_vec_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_vec_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef MISR_FAILLOG_EN
    logic [CNT_W-1:0] r_fail_idx;
    logic [OUT_W-1:0] r_fail_diff;

    // Record only the first mismatch of a run; later ones leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_idx  <= '0;
            r_fail_diff <= '0;
        end else if (w_start_run) begin
            r_fail_idx  <= '0;
            r_fail_diff <= '0;
        end else if (w_accept && w_mismatch && (r_mis_cnt == '0)) begin
            r_fail_idx  <= r_vec_cnt;
            r_fail_diff <= vif.vec_data ^ vif.exp_data;
        end
    end

    assign fail_idx  = r_fail_idx;
    assign fail_diff = r_fail_diff;
`else
    assign fail_idx  = '0;
    assign fail_diff = '0;
`endif

    assign vif.vec_ready = r_vec_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign sig_out       = r_sig;
    assign vec_cnt       = r_vec_cnt;
    assign mis_cnt       = r_mis_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mapped_out_misr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mapped_out_misr
//  Description : Directed self-checking bench for mapped_out_misr with a
//                scoreboard of expected per-accept results. A second instance
//                with CNT_W=4 covers counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mapped_out_misr;

    localparam logic [15:0] c_POLY = 16'h1021;

    logic clk;
    logic rst_n;
    logic start;
    logic busy, done;
    logic [15:0] sig_out, vec_cnt, mis_cnt, fail_idx;
    logic [7:0]  fail_diff;

    logic s_start;
    logic s_busy, s_done;
    logic [15:0] s_sig;
    logic [3:0]  s_vc, s_mc, s_fidx;
    logic [7:0]  s_fdiff;

    int total;
    int bad;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] vc;
        logic [15:0] mc;
        logic        dn;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_sig, m_vc, m_mc;

    mapped_out_misr_if #(.OUT_W(8)) bus ();
    mapped_out_misr_if #(.OUT_W(8)) sbus ();

    mapped_out_misr #(.OUT_W(8), .SIG_W(16), .POLY(16'h1021), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vif       (bus),
        .busy      (busy),
        .done      (done),
        .sig_out   (sig_out),
        .vec_cnt   (vec_cnt),
        .mis_cnt   (mis_cnt),
        .fail_idx  (fail_idx),
        .fail_diff (fail_diff)
    );

    mapped_out_misr #(.OUT_W(8), .SIG_W(16), .POLY(16'h1021), .CNT_W(4)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .vif       (sbus),
        .busy      (s_busy),
        .done      (s_done),
        .sig_out   (s_sig),
        .vec_cnt   (s_vc),
        .mis_cnt   (s_mc),
        .fail_idx  (s_fidx),
        .fail_diff (s_fdiff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ c_POLY;
        return n ^ {8'h00, d};
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_sig = '0;
        m_vc  = '0;
        m_mc  = '0;
    endtask

    // Drive one accepted vector, push the model result, then pop and compare.
    task automatic send(input logic [7:0] d, input logic [7:0] e, input logic last);
        exp_t x;
        exp_t got;
        bus.vec_valid = 1'b1;
        bus.vec_data  = d;
        bus.exp_data  = e;
        bus.vec_last  = last;
        m_sig = misr_step(m_sig, d);
        if (m_vc != 16'hFFFF) m_vc = m_vc + 16'd1;
        if (d != e && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
        x.sig = m_sig; x.vc = m_vc; x.mc = m_mc; x.dn = last;
        sb.push_back(x);
        tick();
        bus.vec_valid = 1'b0;
        bus.vec_data  = 'x;
        bus.exp_data  = 'x;
        bus.vec_last  = 1'b0;
        got = sb.pop_front();
        chk("sb_sig",  32'(sig_out), 32'(got.sig));
        chk("sb_vcnt", 32'(vec_cnt), 32'(got.vc));
        chk("sb_mcnt", 32'(mis_cnt), 32'(got.mc));
        chk("sb_done", 32'(done),    32'(got.dn));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        s_start = 1'b0;
        bus.vec_valid = 1'b0; bus.vec_data = 'x; bus.exp_data = 'x; bus.vec_last = 1'b0;
        sbus.vec_valid = 1'b0; sbus.vec_data = '0; sbus.exp_data = '0; sbus.vec_last = 1'b0;
        m_sig = '0; m_vc = '0; m_mc = '0;
        tick();
        tick();

        // Reset state
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_done",  32'(done),          32'd0);
        chk("rst_ready", 32'(bus.vec_ready), 32'd0);
        chk("rst_sig",   32'(sig_out),       32'd0);
        chk("rst_vcnt",  32'(vec_cnt),       32'd0);
        rst_n = 1'b1;
        tick();

        // Valid held in IDLE: nothing accepted
        bus.vec_valid = 1'b1; bus.vec_data = 8'hFF; bus.exp_data = 8'h00; bus.vec_last = 1'b1;
        repeat (3) tick();
        chk("idle_ready", 32'(bus.vec_ready), 32'd0);
        chk("idle_vcnt",  32'(vec_cnt),       32'd0);
        chk("idle_sig",   32'(sig_out),       32'd0);
        chk("idle_done",  32'(done),          32'd0);
        bus.vec_valid = 1'b0; bus.vec_last = 1'b0;

        // Reset mid-run after 5 accepts
        do_start();
        chk("run_busy",  32'(busy),          32'd1);
        chk("run_ready", 32'(bus.vec_ready), 32'd1);
        for (int i = 0; i < 5; i++) send(8'(i * 37 + 3), 8'(i * 37 + 3), 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mrst_sig",   32'(sig_out),       32'd0);
        chk("mrst_vcnt",  32'(vec_cnt),       32'd0);
        chk("mrst_busy",  32'(busy),          32'd0);
        chk("mrst_ready", 32'(bus.vec_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_idle_ready", 32'(bus.vec_ready), 32'd0);
        chk("mrst_idle_busy",  32'(busy),          32'd0);

        // Single vector
        do_start();
        send(8'h5A, 8'h5A, 1'b1);
        chk("one_sig",  32'(sig_out), 32'h005A);
        chk("one_vcnt", 32'(vec_cnt), 32'd1);
        chk("one_mcnt", 32'(mis_cnt), 32'd0);
        chk("one_done", 32'(done),    32'd1);
        chk("one_busy", 32'(busy),    32'd0);

        // Valid held in DONE: results hold
        bus.vec_valid = 1'b1; bus.vec_data = 8'h33; bus.exp_data = 8'h44; bus.vec_last = 1'b1;
        repeat (3) tick();
        chk("done_ready", 32'(bus.vec_ready), 32'd0);
        chk("done_sig",   32'(sig_out),       32'h005A);
        chk("done_vcnt",  32'(vec_cnt),       32'd1);
        chk("done_mcnt",  32'(mis_cnt),       32'd0);
        chk("done_hold",  32'(done),          32'd1);
        bus.vec_valid = 1'b0; bus.vec_last = 1'b0;

        // Two vectors, second mismatches
        do_start();
        chk("restart_sig",  32'(sig_out), 32'd0);
        chk("restart_done", 32'(done),    32'd0);
        send(8'h5A, 8'h5A, 1'b0);
        send(8'h01, 8'h03, 1'b1);
        chk("two_sig",  32'(sig_out), 32'h00B5);
        chk("two_vcnt", 32'(vec_cnt), 32'd2);
        chk("two_mcnt", 32'(mis_cnt), 32'd1);
`ifdef MISR_FAILLOG_EN
        chk("two_fidx",  32'(fail_idx),  32'd1);
        chk("two_fdiff", 32'(fail_diff), 32'h02);
`else
        chk("two_fidx",  32'(fail_idx),  32'd0);
        chk("two_fdiff", 32'(fail_diff), 32'h00);
`endif

        // start during RUN is ignored, including alongside an accept
        do_start();
`ifdef MISR_FAILLOG_EN
        chk("clr_fidx",  32'(fail_idx),  32'd0);
        chk("clr_fdiff", 32'(fail_diff), 32'h00);
`endif
        send(8'h11, 8'h11, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midstart_vcnt", 32'(vec_cnt), 32'd1);
        chk("midstart_sig",  32'(sig_out), 32'h0011);
        chk("midstart_busy", 32'(busy),    32'd1);
        start = 1'b1;
        send(8'h22, 8'h20, 1'b0);
        start = 1'b0;
        send(8'h00, 8'h00, 1'b1);
        chk("coinc_vcnt", 32'(vec_cnt), 32'd3);
        chk("coinc_mcnt", 32'(mis_cnt), 32'd1);

        // Feedback path exercised by a shifting top bit
        do_start();
        for (int i = 0; i < 16; i++) send(8'h80, 8'h80, 1'b0);
        send(8'h00, 8'h00, 1'b1);
        chk("fb_vcnt", 32'(vec_cnt), 32'd17);
        chk("fb_done", 32'(done),    32'd1);

        // Saturation on the CNT_W=4 instance
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("sat_busy0", 32'(s_busy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            sbus.vec_valid = 1'b1;
            sbus.vec_data  = 8'h01;
            sbus.exp_data  = 8'h00;
            sbus.vec_last  = (i == 19);
            tick();
        end
        sbus.vec_valid = 1'b0;
        sbus.vec_last  = 1'b0;
        chk("sat_vcnt", 32'(s_vc),   32'd15);
        chk("sat_mcnt", 32'(s_mc),   32'd15);
        chk("sat_done", 32'(s_done), 32'd1);
`ifdef MISR_FAILLOG_EN
        chk("sat_fidx",  32'(s_fidx),  32'd0);
        chk("sat_fdiff", 32'(s_fdiff), 32'h01);
`endif
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("sat_clr_vcnt", 32'(s_vc),   32'd0);
        chk("sat_clr_mcnt", 32'(s_mc),   32'd0);
        chk("sat_clr_busy", 32'(s_busy), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
